ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: XLEN, default 32, operand/HI/LO width; iteration count equals XLEN.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 op_valid  input  1  EX-stage instruction valid; control already zeroed on flush/stall upstream.
REQ-005 funct  input  6  EX-stage funct field.
REQ-006 op_a  input  XLEN  rs operand, post-forwarding.
REQ-007 op_b  input  XLEN  rt operand, post-forwarding.
REQ-008 kill  input  1  abort the in-flight operation (exception/branch squash).
REQ-009 busy  output  1  operation in progress.
REQ-010 stall_req  output  1  hold ID/EX and earlier stages this cycle.
REQ-011 done  output  1  one-cycle pulse after a HI/LO result write.
REQ-012 hi  output  XLEN  HI register.
REQ-013 lo  output  XLEN  LO register.

Function
REQ-014 Decoded funct values: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13; all others ignored.
REQ-015 FSM states: IDLE, RUN, FIX; only IDLE accepts new operations.
REQ-016 IDLE, op_valid and MULT/MULTU/DIV/DIVU, kill=0: latch operand magnitudes (absolute value for signed ops), result-sign flags, op kind; clear count; go to RUN.
REQ-017 RUN performs one iteration per cycle (shift-add multiply, restoring divide); after XLEN iterations go to FIX.
REQ-018 FIX negates product, quotient and/or remainder per sign flags (remainder takes dividend sign), writes HI/LO, goes to IDLE.
REQ-019 Latency: start accepted at edge E0; HI/LO written at edge E(XLEN+1) (E33 for XLEN=32); done high for the cycle after that edge.
REQ-020 Multiply: {HI,LO} = full 2*XLEN-bit product. Divide: LO = quotient, HI = remainder, truncation toward zero.
REQ-021 Divide by zero: LO = all ones, HI = op_a; identical latency; no trap.
REQ-022 Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
REQ-023 IDLE, op_valid and MTHI (MTLO): hi (lo) <= op_a at the next edge; other register unchanged; no done pulse.
REQ-024 MFHI/MFLO read hi/lo combinationally; module state unchanged.
REQ-025 busy = (state != IDLE).
REQ-026 stall_req = busy AND op_valid AND funct in {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}; combinational; 0 in IDLE.
REQ-027 Operations presented while busy are ignored (stall_req holds them until IDLE).
REQ-028 kill in RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done pulse.
REQ-029 kill with a start or MTHI/MTLO in IDLE: kill wins; nothing accepted.
REQ-030 Back-to-back: a mul/div presented in the cycle done is high is accepted normally.

Reset
REQ-031 rst low asynchronously forces state IDLE, count 0, hi 0, lo 0, done 0, internal datapath registers 0; busy and stall_req read 0.
REQ-032 Reset mid-operation discards the operation without any HI/LO write; first edge after rst high behaves as IDLE.

Structure
REQ-033 Shared package holds funct constants (REQ-014), the FSM state enumeration, and the divide-by-zero quotient constant.
REQ-034 One sub-module is natural: ex_muldiv_step, combinational single iteration (add/shift or subtract/compare) instantiated once in RUN.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E33, hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy high E0..E33.
REQ-036 MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100 after 33 edges; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 MFLO presented at E5 of a DIVU -> stall_req=1 through E33, 0 after; MFLO then returns new lo.
REQ-039 kill at E10 of MULT with hi=0x11, lo=0x22 -> IDLE at E11, hi/lo stay 0x11/0x22, no done.
REQ-040 rst low at E20 of DIV -> busy=0 immediately, hi=lo=0; MTHI 0x55 after release -> hi=0x55 next edge.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct decode,
// FSM state encoding and the divide-by-zero quotient pattern.
package ex_muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Wide enough for any supported XLEN; users slice the low XLEN bits.
  localparam int MAX_XLEN = 64;
  localparam logic [MAX_XLEN-1:0] DIV0_QUOT = '1;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the sequential datapath: shift-add multiply step or
// restoring divide step on the {acc, shr} working pair.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] shr_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] shr_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shifted;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  // Multiply: shr holds the remaining multiplier bits, acc the upper partial product.
  assign mul_sum     = {1'b0, acc_i} + (shr_i[0] ? {1'b0, opnd_i} : '0);

  // Divide: shift the next dividend bit into the partial remainder.
  assign div_shifted = {acc_i, shr_i[XLEN-1]};
  assign div_diff    = div_shifted - {1'b0, opnd_i};
  assign div_ge      = (div_shifted >= {1'b0, opnd_i});

  always_comb begin
    acc_o = acc_i;
    shr_o = shr_i;
    if (is_div_i) begin
      acc_o = div_ge ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
      shr_o = {shr_i[XLEN-2:0], div_ge};
    end else begin
      acc_o = mul_sum[XLEN:1];
      shr_o = {mul_sum[0], shr_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit for the EX stage.
// Magnitudes are iterated for XLEN cycles, then signs are fixed up in one cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] shr_q, shr_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  logic            is_signed, a_neg, b_neg, start_div;
  logic [XLEN-1:0] step_acc, step_shr;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign a_neg     = is_signed & op_a[XLEN-1];
  assign b_neg     = is_signed & op_b[XLEN-1];
  assign start_div = (funct == F_DIV) || (funct == F_DIVU);

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .shr_i    (shr_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .shr_o    (step_shr)
  );

  // Result sign fix-up; remainder follows the dividend, div-by-zero overrides the quotient.
  assign prod     = {acc_q, shr_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quot_fix = div0_q ? DIV0_QUOT[XLEN-1:0] : (neg_res_q ? -shr_q : shr_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    shr_d     = shr_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && !kill) begin
          if (is_muldiv(funct)) begin
            acc_d     = '0;
            shr_d     = a_neg ? -op_a : op_a;
            opnd_d    = b_neg ? -op_b : op_b;
            is_div_d  = start_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = start_div && (op_b == '0);
            count_d   = '0;
            state_d   = ST_RUN;
          end else if (funct == F_MTHI) begin
            hi_d = op_a;
          end else if (funct == F_MTLO) begin
            lo_d = op_a;
          end
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = step_acc;
          shr_d   = step_shr;
          count_d = count_q + CW'(1);
          if (count_q == LAST_CNT) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!kill) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      shr_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      shr_q     <= shr_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign stall_req = busy && op_valid && (is_muldiv(funct) || is_hilo(funct));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a cycle-count/arithmetic model compared every
// cycle, plus literal expectations for the headline scenarios.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam logic [5:0] T_MFHI = 6'h10, T_MTHI = 6'h11, T_MFLO = 6'h12, T_MTLO = 6'h13;
  localparam logic [5:0] T_MULT = 6'h18, T_MULTU = 6'h19, T_DIV = 6'h1A, T_DIVU = 6'h1B;

  logic            clk, rst, op_valid, kill;
  logic [5:0]      funct;
  logic [XLEN-1:0] op_a, op_b;
  logic            busy, stall_req, done;
  logic [XLEN-1:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_arith(input logic [5:0] f);
    return f == T_MULT || f == T_MULTU || f == T_DIV || f == T_DIVU;
  endfunction

  function automatic logic is_known(input logic [5:0] f);
    return is_arith(f) || f == T_MFHI || f == T_MTHI || f == T_MFLO || f == T_MTLO;
  endfunction

  // Architectural result {HI, LO} straight from integer arithmetic.
  function automatic logic [63:0] model_res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      T_MULT:  p = sa * sb;
      T_MULTU: p = {32'b0, a} * {32'b0, b};
      T_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      T_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Model: busy for XLEN+1 edges after acceptance, then commit and pulse done.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res  = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_res  <= '0;   m_hi   <= '0;   m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (op_valid && !kill) begin
          if (is_arith(funct)) begin
            m_busy <= 1'b1;
            m_left <= XLEN + 1;
            m_res  <= model_res(funct, op_a, op_b);
          end else if (funct == T_MTHI) m_hi <= op_a;
          else if (funct == T_MTLO) m_lo <= op_a;
        end
      end else if (kill) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
        m_done <= 1'b1;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc busy", busy, m_busy);
    chk("cyc done", done, m_done);
    chk("cyc stall_req", stall_req, m_busy && op_valid && is_known(funct));
    chk("cyc hi", hi, m_hi);
    chk("cyc lo", lo, m_lo);
  end

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    op_valid = 1'b1; funct = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0; op_a = '0; op_b = '0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, 33);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    $display("txn %s a=%h b=%h -> hi=%h lo=%h edges=%0d", name, a, b, hi, lo, cyc);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    op_valid = 1'b1; funct = T_MTHI; op_a = h;
    @(posedge clk); #1;
    funct = T_MTLO; op_a = l;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0; op_a = '0;
    $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; op_valid = 1'b0; kill = 1'b0; funct = '0; op_a = '0; op_b = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset stall_req", stall_req, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    #19 rst = 1'b1;
    @(posedge clk); #1;

    write_hilo(32'h11, 32'h22);
    chk("mthi hi", hi, 32'h11);
    chk("mtlo lo", lo, 32'h22);

    // MFHI/MFLO in IDLE leave the unit untouched.
    op_valid = 1'b1; funct = T_MFHI;
    @(posedge clk); #1;
    funct = T_MFLO;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0;
    chk("mfhi idle busy", busy, 0);
    chk("mfhi idle hi", hi, 32'h11);
    $display("txn mfhi/mflo idle hi=%h lo=%h", hi, lo);

    // Back-to-back: each run_op starts in the cycle done is high.
    run_op("multu max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -7x3", T_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/0", T_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div min/-1", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div 7/-2", T_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("mult maxpos", T_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_op("div -100/0", T_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
    run_op("multu shift", T_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);

    // Kill in IDLE beats both a start and an MTHI.
    write_hilo(32'h11, 32'h22);
    op_valid = 1'b1; funct = T_MULT; op_a = 32'd3; op_b = 32'd5; kill = 1'b1;
    @(posedge clk); #1;
    chk("kill idle start busy", busy, 0);
    funct = T_MTHI; op_a = 32'h99;
    @(posedge clk); #1;
    op_valid = 1'b0; kill = 1'b0; funct = '0; op_a = '0; op_b = '0;
    chk("kill idle mthi hi", hi, 32'h11);
    $display("txn kill-in-idle hi=%h busy=%b", hi, busy);

    // Kill during RUN; an unrelated funct while busy must not stall.
    op_valid = 1'b1; funct = T_MULT; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1; op_valid = 1'b1; funct = 6'h20;
    @(posedge clk); #1;
    kill = 1'b0; op_valid = 1'b0; funct = '0; op_a = '0; op_b = '0;
    chk("kill run busy", busy, 0);
    chk("kill run hi", hi, 32'h11);
    chk("kill run lo", lo, 32'h22);
    repeat (40) @(posedge clk);
    #1;
    chk("kill run later lo", lo, 32'h22);
    $display("txn kill-in-run hi=%h lo=%h", hi, lo);

    // Kill in the fix-up cycle suppresses the write.
    op_valid = 1'b1; funct = T_MULTU; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0; op_a = '0; op_b = '0;
    repeat (32) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill fix busy", busy, 0);
    chk("kill fix lo", lo, 32'h22);
    $display("txn kill-in-fix hi=%h lo=%h", hi, lo);

    // MFLO held by stall_req from E5 until the divide commits.
    op_valid = 1'b1; funct = T_DIVU; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0;
    repeat (5) @(posedge clk);
    #1;
    op_valid = 1'b1; funct = T_MFLO; op_a = '0; op_b = '0;
    cnt = 0;
    while (cnt < 60) begin
      @(negedge clk);
      if (stall_req) cnt++;
      else break;
    end
    chk("mflo stall cycles", cnt, 28);
    chk("mflo new lo", lo, 32'd142);
    chk("mflo new hi", hi, 32'd6);
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0;
    $display("txn divu 1000/7 with mflo stall=%0d lo=%h hi=%h", cnt, lo, hi);

    // Asynchronous reset mid-divide.
    op_valid = 1'b1; funct = T_DIV; op_a = 32'd50; op_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0; op_a = '0; op_b = '0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst mid busy", busy, 0);
    chk("rst mid done", done, 0);
    chk("rst mid hi", hi, 0);
    chk("rst mid lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    op_valid = 1'b1; funct = T_MTHI; op_a = 32'h55;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = '0; op_a = '0;
    chk("post rst mthi hi", hi, 32'h55);
    chk("post rst lo", lo, 0);
    $display("txn reset-mid-div then mthi hi=%h lo=%h", hi, lo);

    run_op("multu 6x7", T_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
